// File: rtl/pistorm_pkg.sv
// rtl/pistorm_pkg.sv - shared register map, command bits and descriptor type for the Pi transaction queue
// PI_TXN_QUEUE_FC_EN adds a per-descriptor function code field.
package pistorm_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CMD_BYTE   = 8;
    localparam int CMD_RW     = 9;
    localparam int CMD_FC_LSB = 10;
    localparam int CMD_CLEAR  = 15;

    localparam int ST_BUSY     = 15;
    localparam int ST_FULL     = 14;
    localparam int ST_EMPTY    = 13;
    localparam int ST_OVERFLOW = 12;
    localparam int ST_BERR     = 11;
    localparam int ST_FRESH    = 10;

    localparam int DESC_AW = 24;
    localparam logic [2:0] FC_SUPER_DATA = 3'b101;

    typedef struct packed {
        logic [DESC_AW-1:0] addr;
        logic [15:0]        wdata;
        logic               rw;
        logic               uds_n;
        logic               lds_n;
`ifdef PI_TXN_QUEUE_FC_EN
        logic [2:0]         fc;
`endif
    } txn_desc_t;

    // Idle bus: read, both strobes negated.
    function automatic txn_desc_t desc_idle();
        txn_desc_t d;
        d       = '0;
        d.rw    = 1'b1;
        d.uds_n = 1'b1;
        d.lds_n = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/pi_desc_fifo.sv
// rtl/pi_desc_fifo.sv - DEPTH-entry descriptor FIFO with a registered head output
module pi_desc_fifo
    import pistorm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  txn_desc_t              din,
    output txn_desc_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    txn_desc_t       mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   rptr_nxt;
    logic            push_ok;
    logic            pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign rptr_nxt = pop_ok ? rptr + 1'b1 : rptr;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= din;
        end
    end

    // dout tracks the entry at rptr_nxt; when that slot is being written now, take din directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            dout  <= desc_idle();
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            rptr <= rptr_nxt;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push_ok || pop_ok) begin
                dout <= (push_ok && (wptr == rptr_nxt)) ? din : mem[rptr_nxt];
            end
        end
    end

endmodule

// File: rtl/pi_txn_queue.sv
// rtl/pi_txn_queue.sv - Pi register front end queueing 68k bus descriptors for the sequencer
// PI_TXN_QUEUE_FC_EN: take the function code from ADDR_HI instead of fixed supervisor data.
module pi_txn_queue
    import pistorm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 24
) (
    input  logic          PI_CLK,
    input  logic          RESET_n,
    input  logic          wr_pulse,
    input  logic          rd_pulse,
    input  logic [1:0]    reg_sel,
    input  logic [15:0]   wr_data,
    output logic [15:0]   rd_data,
    output logic          txn_valid,
    input  logic          txn_ready,
    output logic [AW-1:0] txn_addr,
    output logic [15:0]   txn_wdata,
    output logic          txn_rw,
    output logic          txn_uds_n,
    output logic          txn_lds_n,
    output logic [2:0]    txn_fc,
    input  logic          txn_done,
    input  logic [15:0]   txn_rdata,
    input  logic          txn_berr,
    output logic          busy
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [15:0]   stage_wdata;
    logic [15:0]   stage_addr;
    logic [15:0]   rd_result;
    logic          outstanding;
    logic          outstanding_nxt;
    logic          out_rw;
    logic          overflow;
    logic          berr;
    logic          rd_fresh;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          done_ok;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic [LW-1:0] level_nxt;
    logic [4:0]    level_wide;
    logic [15:0]   status;
    txn_desc_t     push_desc;
    txn_desc_t     head;
    logic          unused_bits;

    assign push      = wr_pulse && (reg_sel == REG_ADDR_HI);
    assign txn_valid = !empty && !outstanding;
    assign pop       = txn_valid && txn_ready;
    assign push_ok   = push && (!full || pop);
    assign done_ok   = txn_done && outstanding;
    assign level_nxt = level + LW'(push_ok) - LW'(pop);
    assign level_wide = 5'(level);

    always_comb begin
        outstanding_nxt = outstanding;
        if (pop) begin
            outstanding_nxt = 1'b1;
        end else if (done_ok) begin
            outstanding_nxt = 1'b0;
        end
    end

    always_comb begin
        push_desc       = '0;
        push_desc.addr  = {wr_data[7:0], stage_addr};
        push_desc.wdata = stage_wdata;
        push_desc.rw    = wr_data[CMD_RW];
        // Word access keeps both strobes active and leaves addr[0] as written.
        if (wr_data[CMD_BYTE]) begin
            push_desc.uds_n = push_desc.addr[0];
            push_desc.lds_n = !push_desc.addr[0];
        end else begin
            push_desc.uds_n = 1'b0;
            push_desc.lds_n = 1'b0;
        end
`ifdef PI_TXN_QUEUE_FC_EN
        push_desc.fc = wr_data[CMD_FC_LSB +: 3];
`endif
    end

    always_comb begin
        status              = '0;
        status[ST_BUSY]     = busy;
        status[ST_FULL]     = full;
        status[ST_EMPTY]    = empty;
        status[ST_OVERFLOW] = overflow;
        status[ST_BERR]     = berr;
        status[ST_FRESH]    = rd_fresh;
        status[3:0]         = level_wide[4] ? 4'hF : level_wide[3:0];
    end

    pi_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (PI_CLK),
        .rst_n (RESET_n),
        .push  (push),
        .pop   (pop),
        .din   (push_desc),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign txn_addr  = AW'(head.addr);
    assign txn_wdata = head.wdata;
    assign txn_rw    = head.rw;
    assign txn_uds_n = head.uds_n;
    assign txn_lds_n = head.lds_n;

`ifdef PI_TXN_QUEUE_FC_EN
    assign txn_fc      = head.fc;
    assign unused_bits = ^wr_data[14:13];
`else
    logic fc_seen;

    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            fc_seen <= 1'b0;
        end else if (push_ok) begin
            fc_seen <= 1'b1;
        end
    end

    assign txn_fc      = fc_seen ? FC_SUPER_DATA : 3'b000;
    assign unused_bits = ^wr_data[14:10];
`endif

    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            stage_wdata <= '0;
            stage_addr  <= '0;
            rd_result   <= '0;
            rd_data     <= '0;
            outstanding <= 1'b0;
            out_rw      <= 1'b0;
            overflow    <= 1'b0;
            berr        <= 1'b0;
            rd_fresh    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (wr_pulse && (reg_sel == REG_DATA)) begin
                stage_wdata <= wr_data;
            end
            if (wr_pulse && (reg_sel == REG_ADDR_LO)) begin
                stage_addr <= wr_data;
            end
            outstanding <= outstanding_nxt;
            busy        <= (level_nxt != '0) || outstanding_nxt;
            if (pop) begin
                out_rw <= txn_rw;
            end
            // A flag raised in the same cycle as a clear stays set.
            if (wr_pulse && (reg_sel == REG_STATUS) && wr_data[CMD_CLEAR]) begin
                overflow <= 1'b0;
                berr     <= 1'b0;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (done_ok && txn_berr) begin
                berr <= 1'b1;
            end
            if (rd_pulse && (reg_sel == REG_DATA)) begin
                rd_data  <= rd_result;
                rd_fresh <= 1'b0;
            end else if (rd_pulse && (reg_sel == REG_STATUS)) begin
                rd_data <= status;
            end
            if (done_ok && out_rw) begin
                rd_result <= txn_rdata;
                rd_fresh  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pi_txn_queue.sv
// tb/tb_pi_txn_queue.sv - self-checking bench for pi_txn_queue against a queue-based reference model
module tb_pi_txn_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_pulse;
    logic          rd_pulse;
    logic [1:0]    reg_sel;
    logic [15:0]   wr_data;
    logic [15:0]   rd_data;
    logic          txn_valid;
    logic          txn_ready;
    logic [AW-1:0] txn_addr;
    logic [15:0]   txn_wdata;
    logic          txn_rw;
    logic          txn_uds_n;
    logic          txn_lds_n;
    logic [2:0]    txn_fc;
    logic          txn_done;
    logic [15:0]   txn_rdata;
    logic          txn_berr;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic          rw;
        logic          uds_n;
        logic          lds_n;
        logic [2:0]    fc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_data, m_lo, m_result;
    logic        m_out, m_out_rw, m_ovf, m_berr, m_fresh;

    always #5 clk = ~clk;

    pi_txn_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .PI_CLK    (clk),
        .RESET_n   (rst_n),
        .wr_pulse  (wr_pulse),
        .rd_pulse  (rd_pulse),
        .reg_sel   (reg_sel),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .txn_valid (txn_valid),
        .txn_ready (txn_ready),
        .txn_addr  (txn_addr),
        .txn_wdata (txn_wdata),
        .txn_rw    (txn_rw),
        .txn_uds_n (txn_uds_n),
        .txn_lds_n (txn_lds_n),
        .txn_fc    (txn_fc),
        .txn_done  (txn_done),
        .txn_rdata (txn_rdata),
        .txn_berr  (txn_berr),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        q.delete();
        m_data = '0; m_lo = '0; m_result = '0;
        m_out = 0; m_out_rw = 0; m_ovf = 0; m_berr = 0; m_fresh = 0;
    endtask

    function automatic exp_t make_desc(input logic [15:0] hi);
        exp_t        e;
        logic [23:0] a;
        a       = {hi[7:0], m_lo};
        e.addr  = a[AW-1:0];
        e.wdata = m_data;
        e.rw    = hi[9];
        e.uds_n = hi[8] ? a[0] : 1'b0;
        e.lds_n = hi[8] ? ~a[0] : 1'b0;
`ifdef PI_TXN_QUEUE_FC_EN
        e.fc    = hi[12:10];
`else
        e.fc    = 3'b101;
`endif
        return e;
    endfunction

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        int          lv;
        lv     = q.size();
        s      = '0;
        s[15]  = (lv != 0) || m_out;
        s[14]  = (lv == DEPTH);
        s[13]  = (lv == 0);
        s[12]  = m_ovf;
        s[11]  = m_berr;
        s[10]  = m_fresh;
        s[3:0] = (lv > 15) ? 4'hF : 4'(lv);
        return s;
    endfunction

    function automatic exp_t dut_head();
        exp_t h;
        h.addr = txn_addr; h.wdata = txn_wdata; h.rw = txn_rw;
        h.uds_n = txn_uds_n; h.lds_n = txn_lds_n; h.fc = txn_fc;
        return h;
    endfunction

    task automatic mwr(input logic [1:0] r, input logic [15:0] d);
        reg_sel = r; wr_data = d; wr_pulse = 1'b1;
        case (r)
            2'd0: m_data = d;
            2'd1: m_lo = d;
            2'd2: if (q.size() == DEPTH) m_ovf = 1'b1; else q.push_back(make_desc(d));
            default: if (d[15]) begin m_ovf = 1'b0; m_berr = 1'b0; end
        endcase
        tick();
        wr_pulse = 1'b0;
    endtask

    task automatic mrd(input logic [1:0] r, output logic [15:0] got, output logic [15:0] want);
        want = (r == 2'd0) ? m_result : exp_status();
        reg_sel = r; rd_pulse = 1'b1;
        tick();
        rd_pulse = 1'b0;
        got = rd_data;
        if (r == 2'd0) m_fresh = 1'b0;
    endtask

    task automatic serve(input logic [15:0] rdata, input logic be,
                         output logic ok, output exp_t got, output exp_t want);
        ok = 1'b0; got = '0; want = '0;
        for (int i = 0; i < 16 && !ok; i++) begin
            if (txn_valid) ok = 1'b1; else tick();
        end
        if (ok) begin
            got  = dut_head();
            want = (q.size() != 0) ? q[0] : '0;
            txn_ready = 1'b1; tick(); txn_ready = 1'b0;
            m_out = 1'b1; m_out_rw = want.rw;
            if (q.size() != 0) void'(q.pop_front());
            tick();
            txn_rdata = rdata; txn_berr = be; txn_done = 1'b1;
            tick();
            txn_done = 1'b0; txn_berr = 1'b0;
            m_out = 1'b0;
            if (m_out_rw) begin m_result = rdata; m_fresh = 1'b1; end
            if (be) m_berr = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [15:0] g, w;
        rst_n = 1'b0; wr_pulse = 0; rd_pulse = 0; reg_sel = 0; wr_data = 0;
        txn_ready = 0; txn_done = 0; txn_rdata = 0; txn_berr = 0;
        model_clear();
        #12;
        n_cmp++;
        if ({rd_data, txn_valid, txn_rw, txn_uds_n, txn_lds_n, txn_fc, busy} !== {16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got rd=%h v=%b rw=%b u=%b l=%b fc=%b busy=%b", rd_data, txn_valid, txn_rw, txn_uds_n, txn_lds_n, txn_fc, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
        mrd(2'd3, g, w);
        n_cmp++;
        if (g !== 16'h2000 || g !== w) begin n_bad++; $display("FAIL reset_status: got %h want %h", g, w); end
    endtask

    task automatic test_word_write();
        logic ok; exp_t g, w;
        mwr(2'd1, 16'h1235);
        mwr(2'd2, 16'h0000);
        serve(16'h0, 1'b0, ok, g, w);
        n_cmp++;
        if (!ok || g !== w) begin n_bad++; $display("FAIL word_desc: got %h want %h ok=%b", g, w, ok); end
        n_cmp++;
        if ({g.addr, g.rw, g.uds_n, g.lds_n} !== {24'h001235, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL word_fields: got addr=%h rw=%b u=%b l=%b", g.addr, g.rw, g.uds_n, g.lds_n);
        end
    endtask

    task automatic test_byte_write();
        logic ok; exp_t g, w;
        mwr(2'd0, 16'hBEEF);
        mwr(2'd1, 16'h0001);
        reg_sel = 2'd2; wr_data = 16'h0100; wr_pulse = 1'b1;
        n_cmp++;
        if (txn_valid !== 1'b0) begin n_bad++; $display("FAIL byte_valid_early: got %b want 0", txn_valid); end
        q.push_back(make_desc(16'h0100));
        tick();
        wr_pulse = 1'b0;
        n_cmp++;
        if (txn_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL byte_valid_latency: got v=%b busy=%b want 1 1", txn_valid, busy); end
        serve(16'h0, 1'b0, ok, g, w);
        n_cmp++;
        if (!ok || g !== w || {g.wdata, g.uds_n, g.lds_n} !== {16'hBEEF, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL byte_desc: got %h want %h ok=%b", g, w, ok);
        end
    endtask

    task automatic test_overflow();
        logic ok; exp_t g, w; logic [15:0] gs, ws;
        for (int i = 0; i < 5; i++) begin
            mwr(2'd0, 16'($urandom));
            mwr(2'd1, 16'($urandom));
            mwr(2'd2, 16'($urandom) & 16'h1FFF);
        end
        mrd(2'd3, gs, ws);
        n_cmp++;
        if (gs !== ws || gs !== 16'hD004) begin n_bad++; $display("FAIL overflow_status: got %h want %h", gs, ws); end
        for (int i = 0; i < DEPTH; i++) begin
            serve(16'($urandom), 1'b0, ok, g, w);
            n_cmp++;
            if (!ok || g !== w) begin n_bad++; $display("FAIL overflow_drain%0d: got %h want %h ok=%b", i, g, w, ok); end
        end
        tick(); tick();
        n_cmp++;
        if (txn_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL overflow_fifth: got v=%b busy=%b want 0 0", txn_valid, busy); end
        mwr(2'd3, 16'h8000);
        mrd(2'd3, gs, ws);
        n_cmp++;
        if (gs !== ws || gs[12] !== 1'b0) begin n_bad++; $display("FAIL overflow_clear: got %h want %h", gs, ws); end
    endtask

    task automatic test_read_result();
        logic ok; exp_t g, w; logic [15:0] gs, ws;
        mwr(2'd1, 16'($urandom));
        mwr(2'd2, 16'h0200 | 16'($urandom_range(0, 255)));
        serve(16'h55AA, 1'b0, ok, g, w);
        n_cmp++;
        if (!ok || g !== w || g.rw !== 1'b1) begin n_bad++; $display("FAIL read_desc: got %h want %h ok=%b", g, w, ok); end
        mrd(2'd3, gs, ws);
        n_cmp++;
        if (gs !== ws || gs[10] !== 1'b1) begin n_bad++; $display("FAIL read_fresh_set: got %h want %h", gs, ws); end
        mrd(2'd0, gs, ws);
        n_cmp++;
        if (gs !== ws || gs !== 16'h55AA) begin n_bad++; $display("FAIL read_data: got %h want 55aa", gs); end
        mrd(2'd3, gs, ws);
        n_cmp++;
        if (gs !== ws || gs[10] !== 1'b0 || gs[15] !== 1'b0) begin n_bad++; $display("FAIL read_fresh_clr: got %h want %h", gs, ws); end
    endtask

    task automatic test_berr();
        logic ok; exp_t g, w; logic [15:0] gs, ws;
        mwr(2'd2, 16'h0000);
        serve(16'h0, 1'b1, ok, g, w);
        mrd(2'd3, gs, ws);
        n_cmp++;
        if (!ok || gs !== ws || gs[11] !== 1'b1) begin n_bad++; $display("FAIL berr_set: got %h want %h ok=%b", gs, ws, ok); end
        mwr(2'd3, 16'h8000);
        mrd(2'd3, gs, ws);
        n_cmp++;
        if (gs !== ws || gs[11] !== 1'b0) begin n_bad++; $display("FAIL berr_clear: got %h want %h", gs, ws); end
    endtask

    task automatic test_random();
        logic        mvalid, pop, rd_pending;
        int          op;
        logic [1:0]  r;
        logic [15:0] d, rd_exp, gs, ws;
        exp_t        pushed;
        rd_pending = 1'b0; rd_exp = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (rd_pending) begin
                n_cmp++;
                if (rd_data !== rd_exp) begin n_bad++; $display("FAIL rand_rd c%0d: got %h want %h", cyc, rd_data, rd_exp); end
            end
            mvalid = (q.size() != 0) && !m_out;
            n_cmp++;
            if (txn_valid !== mvalid || busy !== ((q.size() != 0) || m_out)) begin
                n_bad++; $display("FAIL rand_flags c%0d: got v=%b busy=%b want v=%b q=%0d out=%b", cyc, txn_valid, busy, mvalid, q.size(), m_out);
            end
            if (mvalid) begin
                n_cmp++;
                if (dut_head() !== q[0]) begin n_bad++; $display("FAIL rand_head c%0d: got %h want %h", cyc, dut_head(), q[0]); end
            end
            op = $urandom_range(0, 7);
            r  = 2'($urandom_range(0, 2));
            d  = 16'($urandom);
            txn_ready = 1'($urandom);
            txn_done  = m_out && ($urandom_range(0, 2) == 0);
            txn_rdata = 16'($urandom);
            txn_berr  = ($urandom_range(0, 7) == 0);
            wr_pulse  = (op < 4);
            rd_pulse  = (op == 4);
            if (op == 4) r = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
            reg_sel = r; wr_data = d;
            rd_pending = rd_pulse;
            if (rd_pulse) rd_exp = (r == 2'd0) ? m_result : exp_status();
            if (rd_pulse && r == 2'd0) m_fresh = 1'b0;
            pop = mvalid && txn_ready;
            pushed = make_desc(d);
            if (wr_pulse && r == 2'd0) m_data = d;
            if (wr_pulse && r == 2'd1) m_lo = d;
            if (txn_done && m_out) begin
                m_out = 1'b0;
                if (m_out_rw) begin m_result = txn_rdata; m_fresh = 1'b1; end
                if (txn_berr) m_berr = 1'b1;
            end
            if (pop) begin
                m_out = 1'b1; m_out_rw = q[0].rw;
                void'(q.pop_front());
            end
            if (wr_pulse && r == 2'd2) begin
                if (q.size() == DEPTH) m_ovf = 1'b1; else q.push_back(pushed);
            end
            tick();
        end
        wr_pulse = 0; rd_pulse = 0; txn_ready = 0; txn_done = 0; txn_berr = 0;
        mrd(2'd3, gs, ws);
        n_cmp++;
        if (gs !== ws) begin n_bad++; $display("FAIL rand_status_end: got %h want %h", gs, ws); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] gs, ws;
        rst_n = 1'b0; model_clear(); tick();
        @(negedge clk); rst_n = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            mwr(2'd1, 16'($urandom));
            mwr(2'd2, 16'($urandom) & 16'h1FFF);
        end
        txn_ready = 1'b1; tick(); txn_ready = 1'b0;
        m_out = 1'b1; m_out_rw = q[0].rw; void'(q.pop_front());
        mrd(2'd3, gs, ws);
        n_cmp++;
        if (gs !== ws || gs !== 16'h8002) begin n_bad++; $display("FAIL mid_pre_status: got %h want %h", gs, ws); end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({rd_data, txn_valid, txn_rw, txn_uds_n, txn_lds_n, txn_fc, busy} !== {16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got rd=%h v=%b rw=%b u=%b l=%b fc=%b busy=%b", rd_data, txn_valid, txn_rw, txn_uds_n, txn_lds_n, txn_fc, busy);
        end
        model_clear();
        @(negedge clk); rst_n = 1'b1;
        tick();
        mrd(2'd3, gs, ws);
        n_cmp++;
        if (gs !== ws || gs !== 16'h2000) begin n_bad++; $display("FAIL mid_post_status: got %h want %h", gs, ws); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_write();
        test_byte_write();
        test_overflow();
        test_read_result();
        test_berr();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
